// File: rtl/fp_add_pkg.sv
// Shared types and constants for the multi-cycle single-precision adder.
// Working operand layout: {sign, exp, hidden, mant, guard}.
package fp_add_pkg;

  localparam int EXP_W   = 8;
  localparam int MANT_W  = 23;
  localparam int GUARD_W = 4;
  localparam int WORK_W  = 28;

  localparam logic [31:0]      QNAN          = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0] EXP_MAX       = 8'hFF;
  localparam int               ALIGN_CAP_DEF = 27;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_SPECIAL = 3'd1;
  localparam state_t S_ALIGN   = 3'd2;
  localparam state_t S_ADD     = 3'd3;
  localparam state_t S_NORM    = 3'd4;
  localparam state_t S_ROUND   = 3'd5;
  localparam state_t S_DONE    = 3'd6;

  typedef struct packed {
    logic               sign;
    logic [EXP_W-1:0]   exp;
    logic               hidden;
    logic [MANT_W-1:0]  mant;
    logic [GUARD_W-1:0] guard;
  } work_t;

  function automatic logic [WORK_W-1:0] mant28(input work_t w);
    return {w.hidden, w.mant, w.guard};
  endfunction

endpackage

// File: rtl/fp_add_sequencer_if.sv
// Operand-issue and writeback handshake bundle for fp_add_sequencer.
interface fp_add_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  flags;
  logic        busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flags, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flags, busy
  );
endinterface

// File: rtl/fp_unpack37.sv
// Combinational split of an IEEE-754 single into the 37-bit working operand.
// Denormals get an effective exponent of 1 with the hidden bit clear.
module fp_unpack37
  import fp_add_pkg::*;
(
  input  logic [31:0] ieee_i,
  output work_t       op_o,
  output logic        is_nan_o,
  output logic        is_inf_o,
  output logic        is_zero_o,
  output logic        is_denorm_o
);
  logic [EXP_W-1:0]  exp_raw;
  logic [MANT_W-1:0] mant_raw;

  assign exp_raw  = ieee_i[30:23];
  assign mant_raw = ieee_i[22:0];

  assign op_o.sign   = ieee_i[31];
  assign op_o.exp    = (exp_raw == '0) ? 8'd1 : exp_raw;
  assign op_o.hidden = (exp_raw != '0);
  assign op_o.mant   = mant_raw;
  assign op_o.guard  = '0;

  assign is_nan_o    = (exp_raw == EXP_MAX) && (mant_raw != '0);
  assign is_inf_o    = (exp_raw == EXP_MAX) && (mant_raw == '0);
  assign is_zero_o   = (exp_raw == '0) && (mant_raw == '0);
  assign is_denorm_o = (exp_raw == '0) && (mant_raw != '0);
endmodule

// File: rtl/fp_add_sequencer.sv
// Multi-cycle IEEE-754 single adder: align, add, normalize and round one
// step per cycle over one shared shift/add datapath.
module fp_add_sequencer
  import fp_add_pkg::*;
#(
  parameter int ALIGN_CAP = ALIGN_CAP_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  fp_add_sequencer_if.slave   bus
);
  localparam logic [7:0] CAP8 = 8'(ALIGN_CAP);

  work_t ua, ub;
  logic  a_nan, a_inf, a_zero, a_den;
  logic  b_nan, b_inf, b_zero, b_den;

  fp_unpack37 u_unpack_a (
    .ieee_i(bus.a), .op_o(ua), .is_nan_o(a_nan), .is_inf_o(a_inf),
    .is_zero_o(a_zero), .is_denorm_o(a_den)
  );
  fp_unpack37 u_unpack_b (
    .ieee_i(bus.b), .op_o(ub), .is_nan_o(b_nan), .is_inf_o(b_inf),
    .is_zero_o(b_zero), .is_denorm_o(b_den)
  );

  state_t              state_q, state_d;
  logic                x_sign_q, x_sign_d;
  logic signed [9:0]   x_exp_q, x_exp_d;
  logic [WORK_W-1:0]   x_mant_q, x_mant_d;
  logic [WORK_W-1:0]   y_mant_q, y_mant_d;
  logic                sub_q, sub_d;
  logic [7:0]          d_q, d_d;
  logic [WORK_W:0]     sum_q, sum_d;
  logic [31:0]         spec_res_q, spec_res_d;
  logic                spec_nan_q, spec_nan_d;
  logic [31:0]         result_q, result_d;
  logic [2:0]          flags_q, flags_d;
  logic                out_valid_q, out_valid_d;

  logic              accept;
  logic              a_ge_b;
  work_t             opx, opy;
  logic [7:0]        exp_diff;
  logic              rnd_g, rnd_s, rnd_l, rnd_inc;
  logic [24:0]       rnd_sum;
  logic [23:0]       rnd_mant;
  logic signed [9:0] rnd_exp;
  logic              rnd_ovf;

  assign accept = bus.in_valid && (state_q == S_IDLE);

  // Ordering only matters for the datapath; equal magnitudes keep A as X.
  assign a_ge_b   = (ua.exp > ub.exp) ||
                    ((ua.exp == ub.exp) && ({ua.hidden, ua.mant} >= {ub.hidden, ub.mant}));
  assign opx      = a_ge_b ? ua : ub;
  assign opy      = a_ge_b ? ub : ua;
  assign exp_diff = opx.exp - opy.exp;

  assign rnd_g    = sum_q[3];
  assign rnd_s    = |sum_q[2:0];
  assign rnd_l    = sum_q[4];
  assign rnd_inc  = rnd_g && (rnd_s || rnd_l);
  assign rnd_sum  = {1'b0, sum_q[27:4]} + {24'd0, rnd_inc};
  assign rnd_mant = rnd_sum[24] ? rnd_sum[24:1] : rnd_sum[23:0];
  assign rnd_exp  = rnd_sum[24] ? (x_exp_q + 10'sd1) : x_exp_q;
  assign rnd_ovf  = (rnd_exp >= 10'sd255);

  always_comb begin
    state_d     = state_q;
    x_sign_d    = x_sign_q;
    x_exp_d     = x_exp_q;
    x_mant_d    = x_mant_q;
    y_mant_d    = y_mant_q;
    sub_d       = sub_q;
    d_d         = d_q;
    sum_d       = sum_q;
    spec_res_d  = spec_res_q;
    spec_nan_d  = spec_nan_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if ((ua.exp == EXP_MAX) || (ub.exp == EXP_MAX)) begin
            spec_nan_d = a_nan || b_nan || (a_inf && b_inf && (ua.sign != ub.sign));
            spec_res_d = a_inf ? {ua.sign, EXP_MAX, 23'd0} : {ub.sign, EXP_MAX, 23'd0};
            state_d    = S_SPECIAL;
          end else begin
            x_sign_d = opx.sign;
            x_exp_d  = $signed({2'b00, opx.exp});
            x_mant_d = mant28(opx);
            y_mant_d = mant28(opy);
            sub_d    = opx.sign ^ opy.sign;
            d_d      = (exp_diff > CAP8) ? CAP8 : exp_diff;
            state_d  = S_ALIGN;
          end
        end
      end
      S_SPECIAL: begin
        result_d = spec_nan_q ? QNAN : spec_res_q;
        flags_d  = {spec_nan_q, 2'b00};
        state_d  = S_DONE;
      end
      S_ALIGN: begin
        if (d_q == '0) begin
          state_d = S_ADD;
        end else begin
          y_mant_d = {1'b0, y_mant_q[WORK_W-1:1]} | {{(WORK_W-1){1'b0}}, y_mant_q[0]};
          d_d      = d_q - 8'd1;
        end
      end
      S_ADD: begin
        sum_d   = sub_q ? ({1'b0, x_mant_q} - {1'b0, y_mant_q})
                        : ({1'b0, x_mant_q} + {1'b0, y_mant_q});
        state_d = S_NORM;
      end
      S_NORM: begin
        if (sum_q == '0) begin
          x_sign_d = 1'b0;
          x_exp_d  = '0;
          state_d  = S_ROUND;
        end else if (sum_q[WORK_W]) begin
          sum_d   = {1'b0, sum_q[WORK_W:2], sum_q[1] | sum_q[0]};
          x_exp_d = x_exp_q + 10'sd1;
          state_d = S_ROUND;
        end else if (!sum_q[WORK_W-1] && (x_exp_q > 10'sd1)) begin
          sum_d   = {sum_q[WORK_W-1:0], 1'b0};
          x_exp_d = x_exp_q - 10'sd1;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (rnd_ovf) begin
          result_d = {x_sign_q, EXP_MAX, 23'd0};
          flags_d  = 3'b011;
        end else begin
          // A clear hidden bit after rounding means a denormal result.
          result_d = {x_sign_q, rnd_mant[23] ? rnd_exp[7:0] : 8'h00, rnd_mant[22:0]};
          flags_d  = {2'b00, rnd_g || rnd_s};
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_sign_q    <= 1'b0;
      x_exp_q     <= '0;
      x_mant_q    <= '0;
      y_mant_q    <= '0;
      sub_q       <= 1'b0;
      d_q         <= '0;
      sum_q       <= '0;
      spec_res_q  <= '0;
      spec_nan_q  <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_sign_q    <= x_sign_d;
      x_exp_q     <= x_exp_d;
      x_mant_q    <= x_mant_d;
      y_mant_q    <= y_mant_d;
      sub_q       <= sub_d;
      d_q         <= d_d;
      sum_q       <= sum_d;
      spec_res_q  <= spec_res_d;
      spec_nan_q  <= spec_nan_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed self-checking bench for fp_add_sequencer.
module tb_fp_add_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp_add_sequencer_if bus ();

  fp_add_sequencer dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Called #1 after an edge with the DUT idle and out_ready high.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] er, input logic [2:0] ef, input int el);
    int lat;
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(el));
    chk({tag, "_result"},  bus.result, er);
    chk({tag, "_flags"},   32'(bus.flags), 32'(ef));
    $display("op %s: a=%08h b=%08h result=%08h flags=%03b latency=%0d",
             tag, av, bv, bus.result, bus.flags, lat);
    @(posedge clk); #1;
    chk({tag, "_out_valid_clr"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = '0;
    bus.b         = '0;
    #1;
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result",    bus.result,         32'd0);
    chk("rst_flags",     32'(bus.flags),     32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("one_plus_one",   32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3'b000, 5);
    run_op("one_minus_one",  32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 3'b000, 5);
    run_op("tie_even",       32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 3'b001, 29);
    run_op("tie_up",         32'h3F80_0000, 32'h3380_0001, 32'h3F80_0001, 3'b001, 29);
    run_op("overflow",       32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 3'b011, 5);
    run_op("inf_minus_inf",  32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 3'b100, 2);
    run_op("nan_in",         32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 3'b100, 2);
    run_op("neg_inf_plus_1", 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 3'b000, 2);
    run_op("norm_left",      32'h3FC0_0000, 32'hBF80_0000, 32'h3F00_0000, 3'b000, 6);
    run_op("denorm_sum",     32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 3'b000, 5);
    run_op("align_cap",      32'h3F80_0000, 32'h0000_0001, 32'h3F80_0000, 3'b001, 32);

    // Backpressure: result held while out_ready is low; new requests ignored.
    bus.out_ready = 1'b0;
    bus.a         = 32'h3F80_0000;
    bus.b         = 32'h3F80_0000;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'd5);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = 32'h4040_0000;
      bus.b        = 32'h4040_0000;
      @(posedge clk); #1;
      chk("bp_out_valid_held", 32'(bus.out_valid), 32'd1);
      chk("bp_result_held",    bus.result,         32'h4000_0000);
      chk("bp_in_ready_low",   32'(bus.in_ready),  32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_handshake_clr", 32'(bus.out_valid), 32'd0);
    chk("bp_in_ready_rise", 32'(bus.in_ready),  32'd1);
    repeat (8) @(posedge clk);
    #1;
    chk("bp_no_ghost_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_no_ghost_busy",  32'(bus.busy),      32'd0);
    $display("op backpressure: result=%08h held 10 cycles", 32'h4000_0000);

    // Reset in the middle of a long ALIGN.
    bus.a        = 32'h3F80_0000;
    bus.b        = 32'h3380_0000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("mid_rst_busy",      32'(bus.busy),      32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("mid_rst_no_output", 32'(bus.out_valid), 32'd0);
    $display("op mid_reset: operation discarded");
    run_op("after_reset", 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3'b000, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
